// File: rtl/vdu_stebus_pkg.sv
// vdu_stebus_pkg: shared state encoding and default sizing for the STEbus acknowledge generator.
// The ERR state only exists when VDU_STEBUS_TFRERR_EN is defined.
package vdu_stebus_pkg;

    localparam int unsigned DEF_CHANNELS = 2;
    localparam int unsigned DEF_WAIT_W   = 4;
    localparam int unsigned DEF_TIMEOUT  = 64;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_RDY  = 3'd2,
        ST_ACK  = 3'd3,
`ifdef VDU_STEBUS_TFRERR_EN
        ST_ERR  = 3'd4,
`endif
        ST_REL  = 3'd5
    } state_t;

endpackage

// File: rtl/vdu_stebus_arb.sv
// vdu_stebus_arb: fixed-priority chip-select arbiter, lowest index wins.
// cs is active low; grant is one-hot active high. Purely combinational.
module vdu_stebus_arb
    import vdu_stebus_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS
) (
    input  logic [CHANNELS-1:0] i_cs,
    output logic [CHANNELS-1:0] o_grant,
    output logic                o_valid
);

    logic w_found;

    // Walk upwards from channel 0 and grant the first asserted select only.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (!i_cs[i] && !w_found) begin
                o_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    assign o_valid = ~(&i_cs);

endmodule

// File: rtl/vdu_stebus_ack.sv
// vdu_stebus_ack: STEbus DATACK*/TFRERR* generator with per-channel wait states.
// All state advances on the falling edge of clk; reset is asynchronous active high.
// Define VDU_STEBUS_TFRERR_EN to enable the ready timeout and TFRERR* error path.
module vdu_stebus_ack
    import vdu_stebus_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned WAIT_W   = DEF_WAIT_W,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNELS-1:0]        cs,
    input  logic [CHANNELS-1:0]        ready,
    input  logic [CHANNELS*WAIT_W-1:0] wait_cfg,
    output logic                       datack,
    output logic                       tfrerr,
    output logic [CHANNELS-1:0]        sel,
    output logic                       start
);

    localparam bit CFG_OK = (CHANNELS >= 1) && (CHANNELS <= 8) && (WAIT_W >= 1) && (TIMEOUT >= 1);

    // Out-of-range parameter sets elaborate a clearly named empty scope that shows up in review.
    generate
        if (!CFG_OK) begin : g_illegal_parameters
        end
    endgenerate

    state_t              r_state;
    logic [WAIT_W-1:0]   r_cnt;
    logic [CHANNELS-1:0] r_sel;
    logic                r_start;
    logic                r_datack;

    logic [CHANNELS-1:0] w_grant;
    logic                w_valid;
    logic [WAIT_W-1:0]   w_wait_sel;
    logic                w_sel_cs_high;
    logic                w_sel_ready;

    vdu_stebus_arb #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .i_cs    (cs),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    // Wait-state count of the channel the arbiter is currently granting.
    always_comb begin
        w_wait_sel = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (w_grant[i]) begin
                w_wait_sel = w_wait_sel | wait_cfg[i*WAIT_W +: WAIT_W];
            end
        end
    end

    // sel is one-hot, so masking and OR-reducing picks out the selected channel's lines.
    assign w_sel_cs_high = |(cs & r_sel);
    assign w_sel_ready   = |(ready & r_sel);

`ifdef VDU_STEBUS_TFRERR_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

    logic [TCNT_W-1:0] r_tcnt;
    logic              r_tfrerr;

    assign tfrerr = r_tfrerr;
`else
    assign tfrerr = 1'b1;
`endif

    // Transfer FSM: select, wait states, ready check, acknowledge/error, then release.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_sel    <= '0;
            r_start  <= 1'b0;
            r_datack <= 1'b1;
`ifdef VDU_STEBUS_TFRERR_EN
            r_tcnt   <= '0;
            r_tfrerr <= 1'b1;
`endif
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_sel   <= w_grant;
                        r_start <= 1'b1;
                        r_cnt   <= w_wait_sel;
`ifdef VDU_STEBUS_TFRERR_EN
                        r_tcnt  <= '0;
`endif
                        r_state <= (w_wait_sel == '0) ? ST_RDY : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_sel_cs_high) begin
                        r_sel   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_REL;
                    end else begin
                        r_cnt <= r_cnt - WAIT_W'(1);
                        if (r_cnt == WAIT_W'(1)) begin
                            r_state <= ST_RDY;
                        end
                    end
                end
                ST_RDY: begin
                    if (w_sel_cs_high) begin
                        r_sel   <= '0;
                        r_state <= ST_REL;
                    end else if (w_sel_ready) begin
                        r_datack <= 1'b0;
                        r_state  <= ST_ACK;
                    end
`ifdef VDU_STEBUS_TFRERR_EN
                    else if (r_tcnt == TCNT_W'(TIMEOUT - 1)) begin
                        r_tfrerr <= 1'b0;
                        r_state  <= ST_ERR;
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
`endif
                end
                ST_ACK: begin
                    if (w_sel_cs_high) begin
                        r_datack <= 1'b1;
                        r_sel    <= '0;
                        r_state  <= ST_REL;
                    end
                end
`ifdef VDU_STEBUS_TFRERR_EN
                ST_ERR: begin
                    if (w_sel_cs_high) begin
                        r_tfrerr <= 1'b1;
                        r_sel    <= '0;
                        r_state  <= ST_REL;
                    end
                end
`endif
                ST_REL: begin
                    r_datack <= 1'b1;
`ifdef VDU_STEBUS_TFRERR_EN
                    r_tfrerr <= 1'b1;
                    r_tcnt   <= '0;
`endif
                    r_sel    <= '0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_datack <= 1'b1;
                    r_sel    <= '0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign datack = r_datack;
    assign sel    = r_sel;
    assign start  = r_start;

endmodule

// File: tb/tb_vdu_stebus_ack.sv
// tb_vdu_stebus_ack: directed scenarios followed by random cs/ready/wait traffic,
// checked every cycle against a transaction-level model of the acknowledge rules.
module tb_vdu_stebus_ack;

    localparam int unsigned CH = 2;
    localparam int unsigned WW = 4;
    localparam int unsigned TO = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic [CH-1:0]    cs;
    logic [CH-1:0]    ready;
    logic [CH*WW-1:0] wait_cfg;
    logic             datack;
    logic             tfrerr;
    logic [CH-1:0]    sel;
    logic             start;

    vdu_stebus_ack #(
        .CHANNELS (CH),
        .WAIT_W   (WW),
        .TIMEOUT  (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .ready    (ready),
        .wait_cfg (wait_cfg),
        .datack   (datack),
        .tfrerr   (tfrerr),
        .sel      (sel),
        .start    (start)
    );

    always #31 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one transfer described by its start edge, channel and wait count.
    int n_edge      = 0;
    bit m_active    = 1'b0;
    int m_ch        = 0;
    int m_t0        = 0;
    int m_wait      = 0;
    bit m_acked     = 1'b0;
    bit m_err       = 1'b0;
    int m_lowcnt    = 0;
    int m_next_free = 0;
    bit m_start     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_active    = 1'b0;
        m_acked     = 1'b0;
        m_err       = 1'b0;
        m_start     = 1'b0;
        m_lowcnt    = 0;
        m_next_free = 0;
    endtask

    // Apply the rules to the inputs sampled at one falling edge.
    task automatic model_edge();
        int pick;
        n_edge++;
        m_start = 1'b0;
        if (reset) begin
            model_clear();
            return;
        end
        if (!m_active) begin
            if (n_edge >= m_next_free) begin
                pick = -1;
                for (int i = 0; i < int'(CH); i++) begin
                    if (!cs[i] && pick < 0) pick = i;
                end
                if (pick >= 0) begin
                    m_active = 1'b1;
                    m_ch     = pick;
                    m_t0     = n_edge;
                    m_wait   = int'(wait_cfg[pick*WW +: WW]);
                    m_acked  = 1'b0;
                    m_err    = 1'b0;
                    m_lowcnt = 0;
                    m_start  = 1'b1;
                end
            end
        end else if (cs[m_ch]) begin
            m_active    = 1'b0;
            m_next_free = n_edge + 2;
        end else if (!m_acked && !m_err && n_edge >= m_t0 + 1 + m_wait) begin
            if (ready[m_ch]) begin
                m_acked = 1'b1;
            end
`ifdef VDU_STEBUS_TFRERR_EN
            else begin
                m_lowcnt++;
                if (m_lowcnt == int'(TO)) m_err = 1'b1;
            end
`endif
        end
    endtask

    task automatic check_all();
        logic [CH-1:0] es;
        es = m_active ? (CH'(1) << m_ch) : '0;
        chk("datack", 32'(datack), 32'(!(m_active && m_acked)));
        chk("tfrerr", 32'(tfrerr), 32'(!(m_active && m_err)));
        chk("sel",    32'(sel),    32'(es));
        chk("start",  32'(start),  32'(m_start));
        chk("never_both_low", 32'(datack | tfrerr), 32'd1);
    endtask

    // One bus cycle: DUT and model both act on the falling edge, outputs checked on the rising edge.
    task automatic cycle();
        @(negedge clk);
        model_edge();
        @(posedge clk);
        check_all();
    endtask

    bit saw_dl;
    bit saw_tl;

    initial begin
        reset    = 1'b1;
        cs       = '1;
        ready    = '1;
        wait_cfg = {4'd3, 4'd0};
        model_clear();

        // Reset state
        @(posedge clk);
        chk("rst_datack", 32'(datack), 32'd1);
        chk("rst_tfrerr", 32'(tfrerr), 32'd1);
        chk("rst_sel",    32'(sel),    32'd0);
        chk("rst_start",  32'(start),  32'd0);
        reset = 1'b0;

        // Channel 0, zero wait states, ready high
        cs = 2'b10;
        cycle();
        chk("s1_start", 32'(start), 32'd1);
        chk("s1_sel", 32'(sel), 32'd1);
        chk("s1_datack_e0", 32'(datack), 32'd1);
        cycle();
        chk("s1_datack_e1", 32'(datack), 32'd0);
        chk("s1_start_drop", 32'(start), 32'd0);
        repeat (6) cycle();
        cs = 2'b11;
        cycle();
        chk("s1_release", 32'(datack), 32'd1);
        chk("s1_sel_clr", 32'(sel), 32'd0);
        cycle();

        // Channel 1, three wait states
        cs = 2'b01;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("s2_waiting", 32'(datack), 32'd1);
        end
        cycle();
        chk("s2_datack_e4", 32'(datack), 32'd0);
        chk("s2_sel", 32'(sel), 32'd2);
        cs = 2'b11;
        cycle();
        cycle();

        // Simultaneous selects: channel 0 first, channel 1 after an idle cycle
        wait_cfg = '0;
        cs = 2'b00;
        cycle();
        chk("s3_sel0", 32'(sel), 32'd1);
        cycle();
        chk("s3_ack0", 32'(datack), 32'd0);
        repeat (3) cycle();
        cs = 2'b10 ^ 2'b11;
        cs = 2'b10;
        cs = ~2'b01 & 2'b11;
        cs = 2'b01 ^ 2'b11;
        cs = 2'b10;
        cs = 2'b01;
        cycle();
        chk("s3_rel_datack", 32'(datack), 32'd1);
        chk("s3_rel_sel", 32'(sel), 32'd0);
        cycle();
        chk("s3_idle_sel", 32'(sel), 32'd0);
        chk("s3_idle_start", 32'(start), 32'd0);
        cycle();
        chk("s3_sel1", 32'(sel), 32'd2);
        chk("s3_start1", 32'(start), 32'd1);
        cycle();
        chk("s3_ack1", 32'(datack), 32'd0);
        cs = 2'b11;
        cycle();
        cycle();

        // Abort during wait states
        wait_cfg = {4'd0, 4'd5};
        cs = 2'b10;
        cycle();
        cycle();
        cs = 2'b11;
        cycle();
        chk("s4_datack", 32'(datack), 32'd1);
        chk("s4_tfrerr", 32'(tfrerr), 32'd1);
        chk("s4_sel", 32'(sel), 32'd0);
        cycle();
        cs = 2'b10;
        cycle();
        chk("s4_restart", 32'(start), 32'd1);
        cs = 2'b11;
        cycle();
        cycle();

        // Ready held low on channel 0
        wait_cfg = '0;
        ready = 2'b10;
        cs = 2'b10;
        saw_dl = 1'b0;
        saw_tl = 1'b0;
        repeat (200) begin
            cycle();
            if (!datack) saw_dl = 1'b1;
            if (!tfrerr) saw_tl = 1'b1;
        end
        chk("s5_no_datack", 32'(saw_dl), 32'd0);
`ifdef VDU_STEBUS_TFRERR_EN
        chk("s5_tfrerr", 32'(saw_tl), 32'd1);
`else
        chk("s5_tfrerr", 32'(saw_tl), 32'd0);
`endif
        cs = 2'b11;
        ready = 2'b11;
        cycle();
        cycle();

        // Reset while acknowledging, select still held
        wait_cfg = {4'd0, 4'd2};
        cs = 2'b10;
        repeat (3) cycle();
        cycle();
        chk("s6_ack", 32'(datack), 32'd0);
        reset = 1'b1;
        #1;
        model_clear();
        chk("s6_async_datack", 32'(datack), 32'd1);
        chk("s6_async_sel", 32'(sel), 32'd0);
        cycle();
        reset = 1'b0;
        cycle();
        chk("s6_restart", 32'(start), 32'd1);
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("s6_waiting", 32'(datack), 32'd1);
        end
        cycle();
        chk("s6_reack", 32'(datack), 32'd0);
        cs = 2'b11;
        cycle();
        cycle();

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < int'(CH); c++) begin
                if ($urandom_range(0, 5) == 0) cs[c] = ~cs[c];
                if ($urandom_range(0, 3) == 0) ready[c] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) wait_cfg[c*WW +: WW] = WW'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                #1;
                model_clear();
                check_all();
                cycle();
                reset = 1'b0;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
